ysyx_22041461_wb: RTL and testbench

YSYX_22041461_WB -- requirements
Module: ysyx_22041461_WB

---
 rtl/ysyx_22041461_wb.sv | 92 +++++++++
 tb/tb_ysyx_22041461_wb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041461_wb.sv
// Writeback stage: one-entry stage register, 32x64 register file and retire counter.
// Optional build macro WB_BYPASS_EN forwards the pending write to the read ports.
module ysyx_22041461_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WB_valid_in,
  input  logic [63:0] WB_MEM_in,
  input  logic [63:0] WB_EXE_in,
  input  logic [63:0] WB_pc_in,
  input  logic [1:0]  WB_ctrl,
  input  logic [4:0]  WB_rd,
  input  logic        WB_flush,
  input  logic [4:0]  WB_rs1_addr,
  input  logic [4:0]  WB_rs2_addr,
  output logic [63:0] WB_rs1_data,
  output logic [63:0] WB_rs2_data,
  output logic        WB_valid_out,
  output logic [63:0] WB_pc_out,
  output logic [63:0] WB_retire_cnt
);

  logic        valid_q, valid_d;
  logic [1:0]  ctrl_q;
  logic [4:0]  rd_q;
  logic [63:0] mem_q, exe_q, pc_q;
  logic [63:0] cnt_q, cnt_d;
  logic [63:0] regs_q [32];

  logic        retire;
  logic        wen;
  logic [63:0] wdata;

  // A flush kills the held entry and forces a bubble into the stage register.
  assign retire  = valid_q && !WB_flush;
  assign wen     = retire && (ctrl_q != 2'b00) && (rd_q != 5'd0);
  assign valid_d = WB_valid_in && !WB_flush;
  assign cnt_d   = retire ? cnt_q + 64'd1 : cnt_q;

  always_comb begin
    wdata = 64'd0;
    case (ctrl_q)
      2'b01:   wdata = exe_q;
      2'b10:   wdata = mem_q;
      2'b11:   wdata = pc_q + 64'd4;
      default: wdata = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= 2'b00;
      rd_q    <= 5'd0;
      mem_q   <= 64'd0;
      exe_q   <= 64'd0;
      pc_q    <= 64'd0;
      cnt_q   <= 64'd0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= WB_ctrl;
      rd_q    <= WB_rd;
      mem_q   <= WB_MEM_in;
      exe_q   <= WB_EXE_in;
      pc_q    <= WB_pc_in;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 64'd0;
    end else if (wen) begin
      regs_q[rd_q] <= wdata;
    end
  end

  // x0 is forced to zero on read; wen already excludes rd=0 so it is never written.
  always_comb begin
    WB_rs1_data = (WB_rs1_addr == 5'd0) ? 64'd0 : regs_q[WB_rs1_addr];
    WB_rs2_data = (WB_rs2_addr == 5'd0) ? 64'd0 : regs_q[WB_rs2_addr];
`ifdef WB_BYPASS_EN
    if (wen && (WB_rs1_addr == rd_q)) WB_rs1_data = wdata;
    if (wen && (WB_rs2_addr == rd_q)) WB_rs2_data = wdata;
`else
`endif
  end

  assign WB_valid_out  = valid_q;
  assign WB_pc_out     = pc_q;
  assign WB_retire_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_22041461_wb.sv
// Directed, table-driven bench for the writeback stage; honours WB_BYPASS_EN when defined.
module tb_ysyx_22041461_wb;

  logic        clk;
  logic        rst_n;
  logic        validIn;
  logic [63:0] memIn, exeIn, pcIn;
  logic [1:0]  ctrl;
  logic [4:0]  rd;
  logic        flush;
  logic [4:0]  rs1Addr, rs2Addr;
  logic [63:0] rs1Data, rs2Data;
  logic        validOut;
  logic [63:0] pcOut;
  logic [63:0] retireCnt;

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic        valid;
    logic [1:0]  ctrl;
    logic [4:0]  rd;
    logic [63:0] memIn;
    logic [63:0] exeIn;
    logic [63:0] pc;
    logic [63:0] expData;
    logic [63:0] expCnt;
  } vec_t;

  vec_t vecs [9];

  ysyx_22041461_wb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .WB_valid_in  (validIn),
    .WB_MEM_in    (memIn),
    .WB_EXE_in    (exeIn),
    .WB_pc_in     (pcIn),
    .WB_ctrl      (ctrl),
    .WB_rd        (rd),
    .WB_flush     (flush),
    .WB_rs1_addr  (rs1Addr),
    .WB_rs2_addr  (rs2Addr),
    .WB_rs1_data  (rs1Data),
    .WB_rs2_data  (rs2Data),
    .WB_valid_out (validOut),
    .WB_pc_out    (pcOut),
    .WB_retire_cnt(retireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [4:0] r,
                               input logic [63:0] m, input logic [63:0] e, input logic [63:0] p,
                               input logic f);
    validIn = v; ctrl = c; rd = r; memIn = m; exeIn = e; pcIn = p; flush = f;
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 2'b00, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'b01, 5'd5,  64'h1111, 64'h1234, 64'h8000_0000, 64'h1234, 64'd1};
    vecs[1] = '{1'b1, 2'b01, 5'd1,  64'h2222, 64'h7777, 64'h8000_0004, 64'h7777, 64'd2};
    vecs[2] = '{1'b1, 2'b11, 5'd1,  64'h3333, 64'h4444, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'd3};
    vecs[3] = '{1'b1, 2'b10, 5'd0,  64'hDEAD, 64'h5555, 64'h8000_000C, 64'h0, 64'd4};
    vecs[4] = '{1'b1, 2'b10, 5'd10, 64'hCAFE_BABE_0000_0001, 64'h6666, 64'h8000_0010, 64'hCAFE_BABE_0000_0001, 64'd5};
    vecs[5] = '{1'b1, 2'b00, 5'd11, 64'h8888, 64'h0099, 64'h8000_0014, 64'h0, 64'd6};
    vecs[6] = '{1'b0, 2'b01, 5'd12, 64'h9999, 64'h0077, 64'h8000_0018, 64'h0, 64'd6};
    vecs[7] = '{1'b1, 2'b11, 5'd13, 64'hAAAA, 64'hBBBB, 64'h1000, 64'h1004, 64'd7};
    vecs[8] = '{1'b1, 2'b01, 5'd5,  64'hCCCC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 64'd8};

    // Reset: every register, counter and valid cleared.
    bubble();
    rs1Addr = 5'd0; rs2Addr = 5'd0;
    rst_n = 1'b0;
    #2;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1Addr = 5'(i);
      rs2Addr = 5'(31 - i);
      #1;
      checkOutput($sformatf("reset_rs1_x%0d", i), rs1Data, 64'd0);
      checkOutput($sformatf("reset_rs2_x%0d", 31 - i), rs2Data, 64'd0);
    end
    checkOutput("reset_cnt", retireCnt, 64'd0);
    checkOutput("reset_valid_out", {63'd0, validOut}, 64'd0);

    // Table: capture at one edge, write/retire at the next, then read back.
    for (int i = 0; i < 9; i++) begin
      rs1Addr = vecs[i].rd;
      applyStimulus(vecs[i].valid, vecs[i].ctrl, vecs[i].rd, vecs[i].memIn, vecs[i].exeIn, vecs[i].pc, 1'b0);
      step();
      checkOutput($sformatf("vec%0d_valid_out", i), {63'd0, validOut}, {63'd0, vecs[i].valid});
      checkOutput($sformatf("vec%0d_pc_out", i), pcOut, vecs[i].pc);
      bubble();
      step();
      checkOutput($sformatf("vec%0d_rdata", i), rs1Data, vecs[i].expData);
      checkOutput($sformatf("vec%0d_cnt", i), retireCnt, vecs[i].expCnt);
    end

    // Back-to-back retirement, one per cycle.
    applyStimulus(1'b1, 2'b01, 5'd20, 64'h0, 64'h20, 64'h0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b10, 5'd21, 64'h21, 64'h0, 64'h0, 1'b0);
    step();
    checkOutput("b2b_cnt_a", retireCnt, 64'd9);
    applyStimulus(1'b1, 2'b11, 5'd22, 64'h0, 64'h0, 64'h100, 1'b0);
    step();
    checkOutput("b2b_cnt_b", retireCnt, 64'd10);
    bubble();
    step();
    checkOutput("b2b_cnt_c", retireCnt, 64'd11);
    rs1Addr = 5'd20; rs2Addr = 5'd21;
    #1;
    checkOutput("b2b_x20", rs1Data, 64'h20);
    checkOutput("b2b_x21", rs2Data, 64'h21);
    rs1Addr = 5'd22;
    #1;
    checkOutput("b2b_x22", rs1Data, 64'h104);

    // Flush: held write to x7 is dropped, count frozen, bubble captured.
    rs1Addr = 5'd7;
    applyStimulus(1'b1, 2'b01, 5'd7, 64'h0, 64'h111, 64'h0, 1'b0);
    step();
    bubble();
    step();
    checkOutput("flush_pre_x7", rs1Data, 64'h111);
    checkOutput("flush_pre_cnt", retireCnt, 64'd12);
    applyStimulus(1'b1, 2'b01, 5'd7, 64'h0, 64'h222, 64'h0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b01, 5'd8, 64'h0, 64'h333, 64'h0, 1'b1);
    step();
    checkOutput("flush_valid_out", {63'd0, validOut}, 64'd0);
    checkOutput("flush_cnt", retireCnt, 64'd12);
    checkOutput("flush_x7", rs1Data, 64'h111);
    bubble();
    step();
    rs1Addr = 5'd8;
    #1;
    checkOutput("flush_post_cnt", retireCnt, 64'd12);
    checkOutput("flush_x8", rs1Data, 64'h0);

    // Read of the pending destination before its write edge.
    rs2Addr = 5'd3;
    applyStimulus(1'b1, 2'b01, 5'd3, 64'h0, 64'h55, 64'h0, 1'b0);
    step();
    bubble();
    #1;
`ifdef WB_BYPASS_EN
    checkOutput("bypass_x3_pending", rs2Data, 64'h55);
`else
    checkOutput("nobypass_x3_pending", rs2Data, 64'h0);
`endif
    step();
    checkOutput("bypass_x3_after", rs2Data, 64'h55);
    checkOutput("bypass_cnt", retireCnt, 64'd13);

    // Asynchronous reset mid-operation discards the held entry.
    rs1Addr = 5'd5;
    applyStimulus(1'b1, 2'b01, 5'd15, 64'h0, 64'hF00D, 64'h0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cnt", retireCnt, 64'd0);
    checkOutput("midrst_valid_out", {63'd0, validOut}, 64'd0);
    checkOutput("midrst_x5", rs1Data, 64'd0);
    checkOutput("midrst_x3", rs2Data, 64'd0);
    bubble();
    step();
    #2;
    rst_n = 1'b1;
    rs1Addr = 5'd15;
    step();
    checkOutput("midrst_x15", rs1Data, 64'd0);
    checkOutput("midrst_cnt_after", retireCnt, 64'd0);
    rs1Addr = 5'd16;
    applyStimulus(1'b1, 2'b01, 5'd16, 64'h0, 64'h16, 64'h0, 1'b0);
    step();
    bubble();
    step();
    checkOutput("postrst_x16", rs1Data, 64'h16);
    checkOutput("postrst_cnt", retireCnt, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
